// File: rtl/bcd_counter_pkg.sv
// Shared types and constants for the BCD pulse counter and its per-digit slice.
package bcd_counter_pkg;

    localparam logic [3:0] BCD_MAX = 4'd9;

    typedef logic [3:0] digit_t;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_e;

    function automatic digit_t clamp_digit(input digit_t d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit slice: ripple increment/decrement step plus nibble sanitising
// of the load and terminal values.
module bcd_digit
    import bcd_counter_pkg::*;
(
    input  digit_t cur,
    input  logic   up,
    input  logic   cin,
    input  digit_t load_raw,
    input  digit_t top_raw,
    output digit_t nxt,
    output logic   cout,
    output digit_t load_clamp,
    output digit_t top_clamp
);

    always_comb begin
        nxt  = cur;
        cout = 1'b0;
        if (cin) begin
            if (up) begin
                if (cur >= BCD_MAX) begin
                    nxt  = 4'd0;
                    cout = 1'b1;
                end else begin
                    nxt = cur + 4'd1;
                end
            end else begin
                if (cur == 4'd0) begin
                    nxt  = BCD_MAX;
                    cout = 1'b1;
                end else begin
                    nxt = cur - 4'd1;
                end
            end
        end
    end

    assign load_clamp = clamp_digit(load_raw);
    assign top_clamp  = clamp_digit(top_raw);

endmodule

// File: rtl/bcd_pulse_counter.sv
// BCD event counter fed by an asynchronous pulse input: synchroniser, edge
// detect, clear/load/count control and sticky overflow.
module bcd_pulse_counter
    import bcd_counter_pkg::*;
#(
    parameter int N_DIGITS    = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    input  logic                  i_En,
    input  logic                  i_Pulso,
    input  logic                  i_Clr,
    input  logic                  i_Load,
    input  logic [4*N_DIGITS-1:0] i_LoadVal,
    input  logic [4*N_DIGITS-1:0] i_Top,
    input  logic                  i_Dir,
    input  logic                  i_Mode,
    output logic [4*N_DIGITS-1:0] o_Q,
    output logic                  o_Tope,
    output logic                  o_Ovf,
    output logic                  o_Evt
);

    localparam int W = 4 * N_DIGITS;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   edge_q;
    logic                   pulse_evt;

    logic [W-1:0]      q_r;
    logic [W-1:0]      q_nxt;
    logic              ovf_r;
    logic              ovf_nxt;
    logic              evt_r;
    logic              evt_nxt;

    logic [W-1:0]      step_q;
    logic [W-1:0]      load_c;
    logic [W-1:0]      top_c;
    logic [W-1:0]      load_val;
    logic [N_DIGITS:0] carry;
    logic              count_up;
    logic              at_top;

    // Edge flop keeps tracking regardless of i_En so a held-high pulse never counts late.
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_Pulso};
            edge_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign pulse_evt = sync_q[SYNC_STAGES-1] & ~edge_q & i_En;
    assign count_up  = (i_Dir == DIR_UP);
    assign carry[0]  = 1'b1;

    for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
        bcd_digit u_digit (
            .cur        (q_r[4*gi +: 4]),
            .up         (count_up),
            .cin        (carry[gi]),
            .load_raw   (i_LoadVal[4*gi +: 4]),
            .top_raw    (i_Top[4*gi +: 4]),
            .nxt        (step_q[4*gi +: 4]),
            .cout       (carry[gi+1]),
            .load_clamp (load_c[4*gi +: 4]),
            .top_clamp  (top_c[4*gi +: 4])
        );
    end

    // Sanitised BCD vectors order the same as their packed binary form.
    // A borrow out of the top digit means the count was zero; an up count
    // at or above the terminal value (terminal lowered at run time) is also at-top.
    assign at_top   = carry[N_DIGITS] | (count_up && (q_r >= top_c));
    assign load_val = (load_c > top_c) ? top_c : load_c;

    always_comb begin
        q_nxt   = q_r;
        ovf_nxt = ovf_r;
        evt_nxt = 1'b0;
        if (i_Clr) begin
            q_nxt   = '0;
            ovf_nxt = 1'b0;
        end else if (i_Load) begin
            q_nxt = load_val;
        end else if (pulse_evt) begin
            evt_nxt = 1'b1;
            if (at_top) begin
                ovf_nxt = 1'b1;
                if (i_Mode == MODE_WRAP) begin
                    q_nxt = count_up ? '0 : top_c;
                end
            end else begin
                q_nxt = step_q;
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            q_r   <= '0;
            ovf_r <= 1'b0;
            evt_r <= 1'b0;
        end else begin
            q_r   <= q_nxt;
            ovf_r <= ovf_nxt;
            evt_r <= evt_nxt;
        end
    end

    assign o_Q    = q_r;
    assign o_Ovf  = ovf_r;
    assign o_Evt  = evt_r;
    assign o_Tope = count_up ? (q_r == top_c) : (q_r == '0);

endmodule

// File: tb/tb_bcd_pulse_counter.sv
// Scoreboard bench for bcd_pulse_counter: a decimal reference model predicts
// each accepted event; a monitor checks the DUT whenever o_Evt strobes.
module tb_bcd_pulse_counter;

    localparam int ND = 4;
    localparam int SS = 2;
    localparam int W  = 4 * ND;

    logic         i_Clk;
    logic         i_Rst;
    logic         i_En;
    logic         i_Pulso;
    logic         i_Clr;
    logic         i_Load;
    logic [W-1:0] i_LoadVal;
    logic [W-1:0] i_Top;
    logic         i_Dir;
    logic         i_Mode;
    logic [W-1:0] o_Q;
    logic         o_Tope;
    logic         o_Ovf;
    logic         o_Evt;

    bcd_pulse_counter #(.N_DIGITS(ND), .SYNC_STAGES(SS)) dut (
        .i_Clk     (i_Clk),
        .i_Rst     (i_Rst),
        .i_En      (i_En),
        .i_Pulso   (i_Pulso),
        .i_Clr     (i_Clr),
        .i_Load    (i_Load),
        .i_LoadVal (i_LoadVal),
        .i_Top     (i_Top),
        .i_Dir     (i_Dir),
        .i_Mode    (i_Mode),
        .o_Q       (o_Q),
        .o_Tope    (o_Tope),
        .o_Ovf     (o_Ovf),
        .o_Evt     (o_Evt)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    typedef struct {
        logic [W-1:0] q;
        logic         ovf;
        logic         tope;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;
    int   evt_seen = 0;
    int   m_q = 0;
    bit   m_ovf = 1'b0;

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int           x;
        r = '0;
        x = v;
        for (int i = 0; i < ND; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int from_bcd(input logic [W-1:0] b);
        int v;
        int n;
        v = 0;
        for (int i = ND - 1; i >= 0; i--) begin
            n = int'(b[4*i +: 4]);
            if (n > 9) n = 9;
            v = v * 10 + n;
        end
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic model_event();
        int   top;
        exp_t e;
        top = from_bcd(i_Top);
        if (i_Dir) begin
            if (m_q >= top) begin
                m_ovf = 1'b1;
                if (!i_Mode) m_q = 0;
            end else begin
                m_q = m_q + 1;
            end
        end else begin
            if (m_q == 0) begin
                m_ovf = 1'b1;
                if (!i_Mode) m_q = top;
            end else begin
                m_q = m_q - 1;
            end
        end
        e.q    = to_bcd(m_q);
        e.ovf  = m_ovf;
        e.tope = i_Dir ? (m_q == top) : (m_q == 0);
        sb.push_back(e);
    endtask

    task automatic pulse();
        @(negedge i_Clk);
        #($urandom_range(0, 3));
        i_Pulso = 1'b1;
        if (i_En) model_event();
        repeat (4) @(negedge i_Clk);
        i_Pulso = 1'b0;
        repeat (4) @(negedge i_Clk);
    endtask

    task automatic do_load(input logic [W-1:0] v);
        int l;
        int top;
        @(negedge i_Clk);
        i_Load    = 1'b1;
        i_LoadVal = v;
        @(negedge i_Clk);
        i_Load = 1'b0;
        l   = from_bcd(v);
        top = from_bcd(i_Top);
        m_q = (l > top) ? top : l;
        check("load_q", 32'(o_Q), 32'(to_bcd(m_q)));
    endtask

    task automatic do_clr();
        @(negedge i_Clk);
        i_Clr = 1'b1;
        @(negedge i_Clk);
        i_Clr = 1'b0;
        m_q   = 0;
        m_ovf = 1'b0;
        check("clr_q", 32'(o_Q), 32'd0);
        check("clr_ovf", 32'(o_Ovf), 32'd0);
    endtask

    always @(negedge i_Clk) begin
        if (i_Rst && o_Evt) begin
            evt_seen++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_evt: got o_Q=%h with no event expected", o_Q);
            end else begin
                mon_e = sb.pop_front();
                check("evt_q", 32'(o_Q), 32'(mon_e.q));
                check("evt_ovf", 32'(o_Ovf), 32'(mon_e.ovf));
                check("evt_tope", 32'(o_Tope), 32'(mon_e.tope));
            end
        end
    end

    initial begin
        int evt0;
        int r;
        i_Rst     = 1'b0;
        i_En      = 1'b1;
        i_Pulso   = 1'b0;
        i_Clr     = 1'b0;
        i_Load    = 1'b0;
        i_LoadVal = '0;
        i_Top     = 16'h9999;
        i_Dir     = 1'b1;
        i_Mode    = 1'b0;
        repeat (3) @(negedge i_Clk);
        check("rst_q", 32'(o_Q), 32'd0);
        check("rst_ovf", 32'(o_Ovf), 32'd0);
        check("rst_evt", 32'(o_Evt), 32'd0);
        check("rst_tope", 32'(o_Tope), 32'd0);
        i_Rst = 1'b1;
        repeat (2) @(negedge i_Clk);

        // up, wrap, small terminal value
        i_Top = 16'h0012;
        do_clr();
        repeat (13) pulse();
        check("wrap_up_q", 32'(o_Q), 32'h0);
        check("wrap_up_ovf", 32'(o_Ovf), 32'd1);

        // up, saturate at the maximum
        i_Top  = 16'h9999;
        i_Mode = 1'b1;
        do_clr();
        do_load(16'h9998);
        evt0 = evt_seen;
        repeat (3) pulse();
        check("sat_evts", 32'(evt_seen - evt0), 32'd3);
        check("sat_q", 32'(o_Q), 32'h9999);
        check("sat_ovf", 32'(o_Ovf), 32'd1);
        check("sat_tope", 32'(o_Tope), 32'd1);

        // down, wrap
        i_Top  = 16'h0250;
        i_Dir  = 1'b0;
        i_Mode = 1'b0;
        do_clr();
        do_load(16'h0100);
        pulse();
        check("down_borrow_q", 32'(o_Q), 32'h0099);
        do_load(16'h0000);
        pulse();
        check("down_wrap_q", 32'(o_Q), 32'h0250);
        check("down_wrap_ovf", 32'(o_Ovf), 32'd1);

        // load clamping
        i_Top = 16'h0500;
        do_load(16'h0A3F);
        check("load_clamp_q", 32'(o_Q), 32'h0500);

        // clear coincident with the event cycle
        i_Top = 16'h9999;
        i_Dir = 1'b1;
        do_load(16'h0042);
        @(negedge i_Clk);
        i_Pulso = 1'b1;
        @(negedge i_Clk);
        @(negedge i_Clk);
        i_Clr = 1'b1;
        @(negedge i_Clk);
        i_Clr = 1'b0;
        m_q   = 0;
        m_ovf = 1'b0;
        check("clr_coinc_q", 32'(o_Q), 32'd0);
        check("clr_coinc_evt", 32'(o_Evt), 32'd0);
        repeat (3) @(negedge i_Clk);
        i_Pulso = 1'b0;
        repeat (4) @(negedge i_Clk);

        // enable raised while pulse is held high
        i_En = 1'b0;
        @(negedge i_Clk);
        i_Pulso = 1'b1;
        repeat (5) @(negedge i_Clk);
        i_En = 1'b1;
        repeat (5) @(negedge i_Clk);
        check("en_late_q", 32'(o_Q), 32'd0);
        i_Pulso = 1'b0;
        repeat (4) @(negedge i_Clk);
        pulse();
        check("en_resume_q", 32'(o_Q), 32'h0001);

        // asynchronous reset mid-pulse
        do_load(16'h0457);
        @(negedge i_Clk);
        i_Pulso = 1'b1;
        @(negedge i_Clk);
        #2;
        i_Rst = 1'b0;
        #1;
        check("arst_q", 32'(o_Q), 32'd0);
        check("arst_evt", 32'(o_Evt), 32'd0);
        m_q   = 0;
        m_ovf = 1'b0;
        i_Pulso = 1'b0;
        repeat (2) @(negedge i_Clk);
        i_Rst = 1'b1;
        repeat (4) @(negedge i_Clk);
        check("arst_release_q", 32'(o_Q), 32'd0);
        repeat (3) pulse();
        check("arst_after_q", 32'(o_Q), 32'h0003);

        // randomised operations against the reference model
        for (int k = 0; k < 60; k++) begin
            r      = int'($urandom_range(0, 11));
            i_Dir  = 1'($urandom_range(0, 1));
            i_Mode = 1'($urandom_range(0, 1));
            case (r)
                0: i_Top = 16'($urandom);
                1: i_Top = to_bcd(int'($urandom_range(0, 25)));
                2: do_clr();
                3: do_load(16'($urandom));
                4: do_load(to_bcd(int'($urandom_range(0, 30))));
                5: begin
                    i_En = 1'b0;
                    pulse();
                    i_En = 1'b1;
                end
                default: pulse();
            endcase
        end

        repeat (10) @(negedge i_Clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL missing_evt: got %0d events outstanding, expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bcd_pulse_counter.md
BCD_PULSE_COUNTER -- requirements
Module: bcd_pulse_counter

Interface
REQ-001 SHALL have parameter N_DIGITS, default 4: number of BCD digits (1..8).
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchroniser depth on i_Pulso (2..4).
REQ-003 SHALL have port i_Clk, input, 1: single system clock; all state on its rising edge.
REQ-004 SHALL have port i_Rst, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port i_En, input, 1: count enable; when low, pulse events are discarded.
REQ-006 SHALL have port i_Pulso, input, 1: asynchronous pulse source; each rising edge is one event.
REQ-007 SHALL have port i_Clr, input, 1: synchronous clear of count and overflow flag.
REQ-008 SHALL have port i_Load, input, 1: synchronous load of i_LoadVal.
REQ-009 SHALL have port i_LoadVal, input, 4*N_DIGITS: BCD load value; digit 0 in [3:0].
REQ-010 SHALL have port i_Top, input, 4*N_DIGITS: BCD terminal value (quasi-static).
REQ-011 SHALL have port i_Dir, input, 1: 1 = count up, 0 = count down.
REQ-012 SHALL have port i_Mode, input, 1: 0 = wrap, 1 = saturate.
REQ-013 SHALL have port o_Q, output, 4*N_DIGITS: registered BCD count; digit 0 in [3:0].
REQ-014 SHALL have port o_Tope, output, 1: at the terminal value for the current direction.
REQ-015 SHALL have port o_Ovf, output, 1: sticky overflow/underflow flag.
REQ-016 SHALL have port o_Evt, output, 1: one-cycle strobe per accepted count event.

Function
REQ-017 SHALL pass i_Pulso through SYNC_STAGES flops, then one edge-detect flop; event = synchronised high AND previous low.
REQ-018 SHALL update o_Q and assert o_Evt on clock edge SYNC_STAGES+1 after the first edge sampling i_Pulso high.
REQ-019 SHALL keep the edge-detect flop tracking while i_En=0, so raising i_En with i_Pulso held high produces no event.
REQ-020 SHALL apply priority i_Clr > i_Load > event; a coincident event is dropped and o_Evt stays low.
REQ-021 SHALL, on i_Clr, set o_Q=0 and o_Ovf=0 in the same cycle.
REQ-022 SHALL, on i_Load, clamp each nibble >9 to 9, then clamp the result to i_Top if it is above i_Top; i_Top nibbles >9 are read as 9.
REQ-023 SHALL, on an up event with o_Q != i_Top, increment in BCD: digit 9->0 with carry into the next digit; other digits unchanged.
REQ-024 SHALL, on an up event with o_Q == i_Top: wrap mode sets o_Q=0; saturate mode holds o_Q; both set o_Ovf=1.
REQ-025 SHALL, on a down event with o_Q != 0, decrement in BCD: digit 0->9 with borrow into the next digit.
REQ-026 SHALL, on a down event with o_Q == 0: wrap mode sets o_Q=i_Top; saturate mode holds 0; both set o_Ovf=1.
REQ-027 SHALL treat o_Q > i_Top during up count (i_Top lowered at run time) as at-top (REQ-024 applies).
REQ-028 SHALL drive o_Tope = (i_Dir ? o_Q==i_Top : o_Q==0), combinational from registered o_Q.
REQ-029 SHALL assert o_Evt for accepted events including saturated holds; o_Ovf clears only by i_Clr or reset.

Reset
REQ-030 SHALL, while i_Rst=0, immediately force o_Q=0, o_Ovf=0, o_Evt=0, and all synchroniser/edge flops to 0.
REQ-031 SHALL, on i_Rst assertion mid-count, lose any pending in-flight event; no event results from the reset release itself unless i_Pulso rises afterwards.

Structure
REQ-032 SHALL place the BCD_MAX=4'd9 constant, the digit typedef (4-bit) and the mode/direction encodings in the shared package bcd_counter_pkg.
REQ-033 SHALL instantiate N_DIGITS copies of the sub-module bcd_digit (inc/dec, carry/borrow in/out, clamp) via generate; synchroniser and control stay in the top.

Verification
REQ-034 Up, wrap, N_DIGITS=4, i_Top=0x0012, 13 pulses from 0 -> o_Q 0x0001..0x0012, then 0x0000; o_Ovf=1 after the 13th pulse.
REQ-035 Up, saturate, i_Top=0x9999, load 0x9998, 3 pulses -> o_Q 0x9999 held, o_Evt 3 strobes, o_Ovf=1, o_Tope=1.
REQ-036 Down, wrap, i_Top=0x0250, load 0x0100, 1 pulse -> 0x0099; load 0x0000, 1 pulse -> 0x0250, o_Ovf=1.
REQ-037 i_Load with i_LoadVal=0x0A3F and i_Top=0x0500 -> o_Q=0x0500 (nibbles clamp to 0x0939, then top clamp).
REQ-038 Pulse rising coincident with i_Clr at the event cycle -> o_Q=0, o_Evt=0; i_En low during pulse, then raised while high -> no count.
REQ-039 i_Rst low for one cycle at count 0x0457 mid-pulse -> o_Q=0 asynchronously; exactly one count per subsequent i_Pulso rise.
